// File: rtl/lane_swizzle_pkg.sv
// Shared types for the lane swizzle pipe.
// Mode encoding and stats counter width.
package lane_swizzle_pkg;

  typedef enum logic [1:0] {
    MODE_PASS        = 2'd0,
    MODE_SWAP_HALVES = 2'd1,
    MODE_REVERSE     = 2'd2,
    MODE_MAP         = 2'd3
  } mode_e;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/lane_swizzle_fifo.sv
// Registered FIFO with zeroed storage on reset.
// Head entry is read directly; no fall-through.
module lane_swizzle_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = cnt;

  // Pointers are log2(DEPTH) wide so they wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/lane_swizzle_pipe.sv
// Lane permutation in front of a registered FIFO.
// Define LANE_SWIZZLE_STATS_EN for the pop counter.
module lane_swizzle_pipe
  import lane_swizzle_pkg::*;
#(
  parameter  int LANES  = 4,
  parameter  int LANE_W = 2,
  parameter  int DEPTH  = 4,
  localparam int W      = LANES*LANE_W,
  localparam int SW     = $clog2(LANES),
  localparam int LW     = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_mode,
  input  logic [LANES*SW-1:0]   cfg_map,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [LANE_W-1:0]     out_and,
  output logic [LW-1:0]         level,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  mode_e                mode_q;
  logic [LANES*SW-1:0]  map_q;
  logic [W-1:0]         swz;
  logic [LANE_W-1:0]    and_acc;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_PASS;
      for (int i = 0; i < LANES; i++) begin
        map_q[i*SW +: SW] <= SW'(i);
      end
    end else if (cfg_we) begin
      mode_q <= mode_e'(cfg_mode);
      map_q  <= cfg_map;
    end
  end

  function automatic logic [SW-1:0] src_lane(
    input mode_e               m,
    input logic [LANES*SW-1:0] map,
    input int                  i
  );
    logic [SW-1:0] s;
    s = SW'(i);
    unique case (m)
      MODE_PASS:        s = SW'(i);
      MODE_SWAP_HALVES: s = SW'(i) ^ SW'(LANES/2);
      MODE_REVERSE:     s = SW'(LANES-1-i);
      MODE_MAP:         s = map[i*SW +: SW];
      default:          s = SW'(i);
    endcase
    return s;
  endfunction

  // Registered config applies, so a same-cycle cfg_we sees the old mode.
  always_comb begin
    swz = '0;
    for (int i = 0; i < LANES; i++) begin
      swz[i*LANE_W +: LANE_W] =
        in_data[int'(src_lane(mode_q, map_q, i))*LANE_W +: LANE_W];
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  lane_swizzle_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (swz),
    .rdata (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    and_acc = '1;
    for (int i = 0; i < LANES; i++) begin
      and_acc = and_acc & out_data[i*LANE_W +: LANE_W];
    end
  end

  assign out_and = and_acc;

`ifdef LANE_SWIZZLE_STATS_EN
  logic [XFER_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop && (cnt_q != '1)) begin
      cnt_q <= cnt_q + XFER_CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_swizzle_pipe.sv
// Directed bench for lane_swizzle_pipe.
// Vector table for modes plus race, full/wrap and reset sequences.
module tb_lane_swizzle_pipe;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_map;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_and;
  logic [2:0]  level;
  logic [15:0] xfer_cnt;

  int checks;
  int errors;
  int exp_pops;

  lane_swizzle_pipe #(
    .LANES  (4),
    .LANE_W (2),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_mode  (cfg_mode),
    .cfg_map   (cfg_map),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_and   (out_and),
    .level     (level),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] map;
    logic [7:0] din;
    logic [7:0] dout;
    logic [1:0] dand;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [7:0] mp);
    cfg_we   = 1'b1;
    cfg_mode = m;
    cfg_map  = mp;
    step();
    cfg_we   = 1'b0;
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef LANE_SWIZZLE_STATS_EN
    return 16'(exp_pops);
`else
    return 16'h0;
`endif
  endfunction

  logic [7:0] q[$];
  logic [7:0] nxt;
  logic       acc;

  initial begin
    checks   = 0;
    errors   = 0;
    exp_pops = 0;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_mode  = 2'd0;
    cfg_map   = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    vecs[0] = '{2'd0, 8'h00, 8'hE4, 8'hE4, 2'b00};
    vecs[1] = '{2'd1, 8'h00, 8'hE4, 8'h4E, 2'b00};
    vecs[2] = '{2'd2, 8'h00, 8'hE4, 8'h1B, 2'b00};
    vecs[3] = '{2'd3, 8'hAA, 8'hE4, 8'hAA, 2'b10};
    vecs[4] = '{2'd0, 8'h00, 8'hFF, 8'hFF, 2'b11};
    vecs[5] = '{2'd1, 8'h00, 8'hF0, 8'h0F, 2'b00};
    vecs[6] = '{2'd3, 8'h1B, 8'hE4, 8'h1B, 2'b00};
    vecs[7] = '{2'd3, 8'h00, 8'h03, 8'hFF, 2'b11};

    step();
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_and", out_and, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);

    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].mode, vecs[v].map);
      in_valid = 1'b1;
      in_data  = vecs[v].din;
      step();
      in_valid = 1'b0;
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vecs[v].dout);
      chk("vec_and", out_and, vecs[v].dand);
      chk("vec_level", level, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_pops++;
      chk("vec_drain_level", level, 0);
      chk("vec_drain_valid", out_valid, 0);
    end

    // cfg_we and push in the same cycle
    set_cfg(2'd0, 8'h00);
    cfg_we   = 1'b1;
    cfg_mode = 2'd2;
    in_valid = 1'b1;
    in_data  = 8'hE4;
    step();
    cfg_we = 1'b0;
    step();
    in_valid = 1'b0;
    chk("race_level", level, 2);
    chk("race_first", out_data, 8'hE4);
    out_ready = 1'b1;
    step();
    exp_pops++;
    chk("race_second", out_data, 8'h1B);
    step();
    exp_pops++;
    out_ready = 1'b0;
    chk("race_empty", level, 0);

    // fill past full, then streaming push+pop across wrap
    set_cfg(2'd0, 8'h00);
    q.delete();
    nxt = 8'h10;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = nxt;
      chk("fill_in_ready", in_ready, q.size() < 4);
      step();
      if (q.size() < 4) begin
        q.push_back(nxt);
        nxt++;
      end
      chk("fill_hold_head", out_data, q[0]);
    end
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);

    for (int c = 0; c < 10; c++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = nxt;
      chk("wrap_in_ready", in_ready, q.size() < 4);
      chk("wrap_data", out_data, q[0]);
      acc = q.size() < 4;
      step();
      void'(q.pop_front());
      exp_pops++;
      if (acc) begin
        q.push_back(nxt);
        nxt++;
      end
      chk("wrap_level", level, q.size());
    end

    in_valid = 1'b0;
    for (int d = 0; d < 8 && q.size() > 0; d++) begin
      chk("drain_data", out_data, q[0]);
      step();
      void'(q.pop_front());
      exp_pops++;
    end
    out_ready = 1'b0;
    chk("drain_level", level, 0);

    // reset with three words pending
    set_cfg(2'd2, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_level", level, 3);
    chk("pre_rst_xfer_cnt", xfer_cnt, exp_cnt());
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_pops = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_xfer_cnt", xfer_cnt, 0);
    in_valid = 1'b1;
    in_data  = 8'hE4;
    step();
    in_valid = 1'b0;
    chk("post_rst_pass", out_data, 8'hE4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_pops++;
    chk("post_rst_xfer_cnt", xfer_cnt, exp_cnt());

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_swizzle_pipe.md
# lane_swizzle_pipe

- Parametrised lane-shuffling buffer: accepts words of `LANES` lanes × `LANE_W` bits over a valid/ready handshake.
- Permutes the lanes according to a runtime-selected mode (pass, half-swap, reverse, programmable map) and stores the results in a small registered FIFO.
- Presents each stored word with an AND-fold across lanes.
- Generalises the fixed nibble-swap/register paths of the split-variable test modules into a reusable block between a producer and consumer in the same datapath.

## Interface

Parameters:
- `LANES`, 4, lane count; power of two, ≥2.
- `LANE_W`, 2, bits per lane; ≥1.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `cfg_we` in 1: load `cfg_mode` and `cfg_map`.
- `cfg_mode` in 2: mode, `mode_e`.
- `cfg_map` in `LANES*$clog2(LANES)`: field i = source lane for output lane i.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in `LANES*LANE_W`: producer handshake.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out `LANES*LANE_W`: consumer handshake.
- `out_and` out `LANE_W`: bitwise AND of all lanes of `out_data`.
- `level` out `$clog2(DEPTH+1)`: current FIFO occupancy.
- `xfer_cnt` out 16: transferred-word counter (see Configuration).

## Operation

- Modes:
  - `MODE_PASS` = 0: output lane i = input lane i.
  - `MODE_SWAP_HALVES` = 1: lane i ↔ lane i±`LANES`/2.
  - `MODE_REVERSE` = 2: lane i = input lane `LANES`-1-i.
  - `MODE_MAP` = 3: lane i = input lane `cfg_map[i]`.
- Lane 0 = `in_data[LANE_W-1:0]`.
- Config registers reset to `MODE_PASS`, identity map. `cfg_we` updates them at the clock edge.
- A word accepted in the same cycle as `cfg_we` uses the old config. Words already stored are never re-permuted.
- Permutation happens before storage; the FIFO holds swizzled words.
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- `in_ready` = (`level` < `DEPTH`). There is no push-through when full, even with a simultaneous pop.
- `out_valid` = (`level` != 0). `out_data` = head entry, `out_and` derived combinationally from it.
- Simultaneous push and pop: `level` unchanged, pointers both advance. Pointers wrap modulo `DEPTH`.
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0, `level` = 0.
  - `out_data` = 0, `out_and` = 0. Storage is zeroed, so the head reads 0.
  - `xfer_cnt` = 0.
- Reset mid-operation flushes all entries; pending words are lost.

## Timing

- Latency: a word pushed at edge t is visible on `out_data` with `out_valid` = 1 after edge t (one cycle). Empty-FIFO fall-through does not exist.
- `out_data` stable while `out_valid && !out_ready`.
- `in_ready` depends only on registered `level`, never on `out_ready`. There is no combinational in→out path except `out_and` from `out_data`.
- Full throughput: one word per cycle sustained when `out_ready` held high.

## Configuration

- `LANE_SWIZZLE_STATS_EN` defined:
  - `xfer_cnt` increments on each pop.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: `xfer_cnt` tied to 0, no counter flops.

## Structure

- `lane_swizzle_pkg`: `mode_e` enum (`MODE_PASS`, `MODE_SWAP_HALVES`, `MODE_REVERSE`, `MODE_MAP`), `XFER_CNT_W` = 16.
- Sub-module `lane_swizzle_fifo`: parametrised `DEPTH` × width storage with pointers, `level`, full/empty. The top holds config registers, permutation network, `out_and` and the stats counter.

## Test plan

All scenarios use defaults (`LANES`=4, `LANE_W`=2); lanes 3..0 = 3,2,1,0.
- PASS: push `in_data`=8'hE4 → next cycle `out_data`=8'hE4, `out_and`=2'b00.
- Modes on 8'hE4:
  - `cfg_we`, `MODE_SWAP_HALVES` → 8'h4E.
  - `MODE_REVERSE` → 8'h1B.
  - `MODE_MAP` with `cfg_map`=8'hAA (all lanes←lane 2) → `out_data`=8'hAA, `out_and`=2'b10.
- Config race: `cfg_we` to REVERSE in the same cycle as pushing 8'hE4 → that word exits 8'hE4. The next push of 8'hE4 exits 8'h1B.
- Full and wrap:
  - `out_ready`=0, push 5 words → `in_ready` drops after the 4th, `level`=4.
  - Then push+pop for 10 cycles → output order preserved across pointer wrap.
- Reset:
  - Assert `rst_n`=0 for one edge with `level`=3 → `out_valid`=0, `level`=0, `in_ready`=1, mode back to PASS.
  - With `LANE_SWIZZLE_STATS_EN`, `xfer_cnt` returns to 0.
